// File: rtl/pipeline_hazard_controller_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Holds the fetch-shadow state type, 5-stage index names and the perf select encoding.
package pipeline_hazard_controller_pkg;

   typedef enum logic {
      IDLE   = 1'b0,
      SHADOW = 1'b1
   } shadow_state_t;

   localparam int STAGE_FETCH     = 0;
   localparam int STAGE_DECODE    = 1;
   localparam int STAGE_EXECUTE   = 2;
   localparam int STAGE_MEMORY    = 3;
   localparam int STAGE_WRITEBACK = 4;

   localparam int PERF_SEL_REDIRECT = 5;

   // Counter width able to hold max_value, never narrower than one bit.
   function automatic int width_for(input int max_value);
      return (max_value > 1) ? $clog2(max_value + 1) : 1;
   endfunction

endpackage

// File: rtl/pipeline_hazard_controller_if.sv
// Per-stage hazard request/control bundle between the pipeline and the hazard controller.
// The pipeline side uses the master modport, the controller the slave modport.
interface pipeline_hazard_controller_if #(
   parameter int NUM_STAGES = 5
);
   logic [NUM_STAGES-1:0] stall_req;
   logic [NUM_STAGES-1:0] flush_req;
   logic [NUM_STAGES-1:0] hold;
   logic [NUM_STAGES-1:0] kill;
   logic [NUM_STAGES-1:0] bubble;

   modport master (
      output stall_req, flush_req,
      input  hold, kill, bubble
   );

   modport slave (
      input  stall_req, flush_req,
      output hold, kill, bubble
   );
endinterface

// File: rtl/pipeline_hazard_controller_counter.sv
// Saturating up-counter shared by the stall watchdog and the performance counters.
// Clear wins over increment; counting stops once the ceiling is reached.
module hazard_saturating_counter #(
   parameter int WIDTH = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             inc,
   input  logic             clear,
   input  logic [WIDTH-1:0] ceiling,
   output logic [WIDTH-1:0] count
);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (inc && (count < ceiling)) begin
         count <= count + WIDTH'(1);
      end
   end

endmodule

// File: rtl/pipeline_hazard_controller.sv
// N-stage stall/flush controller with fetch-shadow sequencer, stall watchdog and
// optional performance counters enabled by defining HAZARD_PERF_COUNTERS_EN.
module pipeline_hazard_controller
   import pipeline_hazard_controller_pkg::*;
#(
   parameter int NUM_STAGES    = 5,
   parameter int FETCH_SHADOW  = 2,
   parameter int STALL_TIMEOUT = 1024,
   parameter int COUNTER_WIDTH = 32,
   parameter int CORE          = 0
) (
   input  logic                            clock,
   input  logic                            reset,
   pipeline_hazard_controller_if.slave     hz,
   input  logic                            wdog_clear,
   output logic                            wdog_timeout,
   input  logic [$clog2(NUM_STAGES+1)-1:0] perf_sel,
   output logic [COUNTER_WIDTH-1:0]        perf_data,
   input  logic                            scan
);

   localparam int SEL_W = $clog2(NUM_STAGES + 1);
   localparam int SH_W  = width_for(FETCH_SHADOW);
   localparam int WD_W  = width_for(STALL_TIMEOUT);

   logic [NUM_STAGES-1:0] raw_hold;
   logic [NUM_STAGES-1:0] honoured;
   logic [NUM_STAGES-1:0] squash;
   logic [NUM_STAGES-1:0] hold_out;
   logic [NUM_STAGES-1:0] kill_out;
   logic                  stall_acc;
   logic                  redirect_acc;
   logic                  redirect;
   logic                  any_hold;

   shadow_state_t         state;
   shadow_state_t         state_next;
   logic [SH_W-1:0]       shadow_count;
   logic [SH_W-1:0]       shadow_count_next;
   logic [WD_W-1:0]       wdog_count;
   logic                  unused_inputs;

   // An older stall freezes every younger stage.
   always_comb begin
      stall_acc = 1'b0;
      raw_hold  = '0;
      for (int i = NUM_STAGES - 1; i >= 0; i--) begin
         stall_acc   = stall_acc | hz.stall_req[i];
         raw_hold[i] = stall_acc;
      end
   end

   assign honoured = hz.flush_req & ~raw_hold;
   assign redirect = |honoured;

   // Stages younger than the oldest honoured redirect are squashed.
   always_comb begin
      redirect_acc = 1'b0;
      squash       = '0;
      for (int i = NUM_STAGES - 1; i >= 0; i--) begin
         squash[i]    = redirect_acc;
         redirect_acc = redirect_acc | honoured[i];
      end
   end

   always_comb begin
      hold_out = raw_hold & ~squash;
      kill_out = squash;
      if (state == SHADOW) begin
         hold_out[0] = 1'b0;
         kill_out[0] = 1'b1;
      end
   end

   assign hz.hold   = hold_out;
   assign hz.kill   = kill_out;
   assign hz.bubble = {hold_out[NUM_STAGES-2:0] & ~hold_out[NUM_STAGES-1:1], 1'b0};

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state        <= IDLE;
         shadow_count <= '0;
      end else begin
         state        <= state_next;
         shadow_count <= shadow_count_next;
      end
   end

   // A fresh redirect (re)loads the shadow; otherwise it counts down to IDLE.
   always_comb begin
      state_next        = state;
      shadow_count_next = shadow_count;
      if (redirect && (FETCH_SHADOW > 0)) begin
         state_next        = SHADOW;
         shadow_count_next = SH_W'(FETCH_SHADOW);
      end else if (state == SHADOW) begin
         if (shadow_count == SH_W'(1)) begin
            state_next        = IDLE;
            shadow_count_next = '0;
         end else begin
            shadow_count_next = shadow_count - SH_W'(1);
         end
      end
   end

   assign any_hold = |hold_out;

   hazard_saturating_counter #(.WIDTH(WD_W)) u_wdog_counter (
      .clock   (clock),
      .reset   (reset),
      .inc     (any_hold),
      .clear   (wdog_clear | ~any_hold),
      .ceiling (WD_W'(STALL_TIMEOUT)),
      .count   (wdog_count)
   );

   // Flag sets on the hold cycle that brings the count to the timeout.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wdog_timeout <= 1'b0;
      end else if (wdog_clear) begin
         wdog_timeout <= 1'b0;
      end else if ((STALL_TIMEOUT != 0) && any_hold &&
                   (wdog_count >= WD_W'(STALL_TIMEOUT - 1))) begin
         wdog_timeout <= 1'b1;
      end
   end

`ifdef HAZARD_PERF_COUNTERS_EN
   logic [NUM_STAGES:0]      perf_inc;
   logic [COUNTER_WIDTH-1:0] perf_count [NUM_STAGES+1];

   assign perf_inc = {redirect, hold_out};

   for (genvar g = 0; g <= NUM_STAGES; g++) begin : g_perf
      hazard_saturating_counter #(.WIDTH(COUNTER_WIDTH)) u_perf_counter (
         .clock   (clock),
         .reset   (reset),
         .inc     (perf_inc[g]),
         .clear   (1'b0),
         .ceiling ({COUNTER_WIDTH{1'b1}}),
         .count   (perf_count[g])
      );
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         perf_data <= '0;
      end else if (perf_sel <= SEL_W'(NUM_STAGES)) begin
         perf_data <= perf_count[perf_sel];
      end else begin
         perf_data <= '0;
      end
   end

   assign unused_inputs = ^{scan, 32'(CORE)};
`else
   assign perf_data     = '0;
   assign unused_inputs = ^{scan, perf_sel, 32'(CORE)};
`endif

endmodule
